hall_call_arbiter: RTL and testbench

// Upstream feeder for the 4-floor lift controller. It captures pulses from the six

---
 rtl/hall_call_arbiter_if.sv | 25 ++
 rtl/hall_call_arbiter.sv | 129 ++++++++++++
 tb/tb_hall_call_arbiter.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/hall_call_arbiter_if.sv
// Hall-call button / lift-request bundle between the button panel side and the arbiter.
// The master side drives buttons and hold; the slave (arbiter) returns request and lamps.
interface hall_call_arbiter_if;
  logic [5:0] btn;
  logic       hold;
  logic [2:0] req_code;
  logic       req_valid;
  logic [5:0] pending;

  modport master (
    output btn,
    output hold,
    input  req_code,
    input  req_valid,
    input  pending
  );

  modport slave (
    input  btn,
    input  hold,
    output req_code,
    output req_valid,
    output pending
  );
endinterface

// File: rtl/hall_call_arbiter.sv
// Latches hall-call presses and issues them one at a time, round-robin, as lift request
// codes, with a programmable idle gap after each issue to cover the lift's busy state.
module hall_call_arbiter #(
  parameter int       GAP_CYCLES = 1,
  parameter logic [2:0] IDLE_CODE = 3'b000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hall_call_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] pending_q, pending_d;
  logic [2:0] req_code_q, req_code_d;
  logic       req_valid_q, req_valid_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] last_grant_q, last_grant_d;
  logic [2:0] grant_s;
  logic [5:0] clr_s;

  function automatic logic [2:0] call_code(input logic [2:0] idx);
    logic [2:0] code;
    case (idx)
      3'd0:    code = 3'b001;
      3'd1:    code = 3'b010;
      3'd2:    code = 3'b011;
      3'd3:    code = 3'b110;
      3'd4:    code = 3'b111;
      3'd5:    code = 3'b100;
      default: code = IDLE_CODE;
    endcase
    return code;
  endfunction

  // Search starts just after the last grant; out-of-range last grants restart at bit 0.
  function automatic logic [2:0] rr_pick(input logic [5:0] req, input logic [2:0] last);
    logic [2:0] idx;
    logic [2:0] pick;
    logic       found;
    pick  = 3'd0;
    found = 1'b0;
    idx   = (last >= 3'd5) ? 3'd0 : last + 3'd1;
    for (int k = 0; k < 6; k++) begin
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
      idx = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    end
    return pick;
  endfunction

  // Next-state, grant and capture logic
  always_comb begin
    state_d      = state_q;
    req_code_d   = IDLE_CODE;
    req_valid_d  = 1'b0;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    clr_s        = 6'd0;
    grant_s      = rr_pick(pending_q, last_grant_q);
    case (state_q)
      IDLE: begin
        if (!bus.hold && (pending_q != 6'd0)) begin
          state_d      = ISSUE;
          req_code_d   = call_code(grant_s);
          req_valid_d  = 1'b1;
          clr_s        = 6'(6'd1 << grant_s);
          last_grant_d = grant_s;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (GAP_CYCLES == 0) begin
          state_d = IDLE;
        end else begin
          state_d = GAP;
          cnt_d   = 4'(GAP_CYCLES - 1);
        end
      end
      GAP: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    // A press on the bit being granted this edge is absorbed by the clear.
    pending_d = (pending_q | bus.btn) & ~clr_s;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pending_q    <= 6'd0;
      req_code_q   <= IDLE_CODE;
      req_valid_q  <= 1'b0;
      cnt_q        <= 4'd0;
      last_grant_q <= 3'd5;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      req_code_q   <= req_code_d;
      req_valid_q  <= req_valid_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.req_code  = req_code_q;
  assign bus.req_valid = req_valid_q;
  assign bus.pending   = pending_q;

endmodule

// File: tb/tb_hall_call_arbiter.sv
// Directed bench for hall_call_arbiter (GAP_CYCLES=1): reset, latency, rotation,
// hold, absorb/duplicate presses and asynchronous reset mid-gap.
module tb_hall_call_arbiter;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  int   n_hits;

  hall_call_arbiter_if bus_if ();

  hall_call_arbiter #(
    .GAP_CYCLES(1),
    .IDLE_CODE (3'b000)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [2:0] rr_codes [6] = '{3'b001, 3'b010, 3'b011, 3'b110, 3'b111, 3'b100};
  logic [5:0] rr_pend  [6] = '{6'b111110, 6'b111100, 6'b111000, 6'b110000, 6'b100000, 6'b000000};

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus_if.btn  = 6'd0;
    bus_if.hold = 1'b0;
    #3;
    check("rst_code", {5'd0, bus_if.req_code}, 8'd0);
    check("rst_valid", {7'd0, bus_if.req_valid}, 8'd0);
    check("rst_pending", {2'd0, bus_if.pending}, 8'd0);
    tick(1);
    rst_n = 1'b1;
    tick(3);
    check("empty_idle_valid", {7'd0, bus_if.req_valid}, 8'd0);

    // Single call: 3U
    bus_if.btn = 6'b000100;
    tick(1);
    bus_if.btn = 6'd0;
    check("single_pend_set", {2'd0, bus_if.pending}, 8'b00000100);
    check("single_not_yet", {7'd0, bus_if.req_valid}, 8'd0);
    tick(1);
    check("single_valid", {7'd0, bus_if.req_valid}, 8'd1);
    check("single_code", {5'd0, bus_if.req_code}, 8'b00000011);
    check("single_pend_clr", {2'd0, bus_if.pending}, 8'd0);
    tick(1);
    check("single_one_cycle", {7'd0, bus_if.req_valid}, 8'd0);
    check("single_code_idle", {5'd0, bus_if.req_code}, 8'd0);
    tick(1);

    // Round-robin over all six from a fresh reset
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    tick(1);
    bus_if.btn = 6'b111111;
    tick(1);
    bus_if.btn = 6'd0;
    check("rr_full", {2'd0, bus_if.pending}, 8'b00111111);
    for (int i = 0; i < 6; i++) begin
      tick(1);
      check("rr_valid", {7'd0, bus_if.req_valid}, 8'd1);
      check("rr_code", {5'd0, bus_if.req_code}, {5'd0, rr_codes[i]});
      check("rr_pend", {2'd0, bus_if.pending}, {2'd0, rr_pend[i]});
      tick(1);
      check("rr_gap", {7'd0, bus_if.req_valid}, 8'd0);
      tick(1);
      check("rr_idle", {7'd0, bus_if.req_valid}, 8'd0);
    end

    // Rotation: after 2U, 3D must beat 1U
    bus_if.btn = 6'b000010;
    tick(1);
    bus_if.btn = 6'd0;
    tick(1);
    check("rot_2u", {5'd0, bus_if.req_code}, 8'b00000010);
    bus_if.btn = 6'b010001;
    tick(1);
    bus_if.btn = 6'd0;
    check("rot_pend", {2'd0, bus_if.pending}, 8'b00010001);
    tick(2);
    check("rot_3d_first", {5'd0, bus_if.req_code}, 8'b00000111);
    check("rot_3d_valid", {7'd0, bus_if.req_valid}, 8'd1);
    tick(3);
    check("rot_1u_second", {5'd0, bus_if.req_code}, 8'b00000001);
    check("rot_1u_valid", {7'd0, bus_if.req_valid}, 8'd1);
    tick(2);

    // hold blocks issue, presses still latch
    bus_if.hold = 1'b1;
    bus_if.btn  = 6'b100000;
    tick(1);
    bus_if.btn = 6'd0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("hold_blocked", {7'd0, bus_if.req_valid}, 8'd0);
    end
    check("hold_pend", {2'd0, bus_if.pending}, 8'b00100000);
    bus_if.hold = 1'b0;
    tick(1);
    check("hold_release_code", {5'd0, bus_if.req_code}, 8'b00000100);
    check("hold_release_valid", {7'd0, bus_if.req_valid}, 8'd1);
    tick(2);

    // Press on the issuing edge is absorbed
    bus_if.btn = 6'b000100;
    tick(1);
    tick(1);
    bus_if.btn = 6'd0;
    check("absorb_code", {5'd0, bus_if.req_code}, 8'b00000011);
    check("absorb_pend", {2'd0, bus_if.pending}, 8'd0);
    n_hits = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (bus_if.req_valid) n_hits++;
    end
    check("absorb_no_repeat", 8'(n_hits), 8'd0);

    // Duplicate presses of a pending 2D yield one code
    bus_if.hold = 1'b1;
    bus_if.btn  = 6'b001000;
    tick(1);
    bus_if.btn = 6'd0;
    tick(1);
    bus_if.btn = 6'b001000;
    tick(1);
    bus_if.btn = 6'd0;
    check("dup_pend", {2'd0, bus_if.pending}, 8'b00001000);
    bus_if.hold = 1'b0;
    n_hits = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (bus_if.req_valid && bus_if.req_code == 3'b110) n_hits++;
    end
    check("dup_single_issue", 8'(n_hits), 8'd1);
    check("dup_pend_clr", {2'd0, bus_if.pending}, 8'd0);

    // Async reset in GAP with pending=101010; last grant is 2D so 3D goes first
    bus_if.btn = 6'b111010;
    tick(1);
    bus_if.btn = 6'd0;
    tick(1);
    check("gap_setup_code", {5'd0, bus_if.req_code}, 8'b00000111);
    tick(1);
    check("gap_setup_pend", {2'd0, bus_if.pending}, 8'b00101010);
    #2;
    rst_n = 1'b0;
    #1;
    check("midgap_rst_code", {5'd0, bus_if.req_code}, 8'd0);
    check("midgap_rst_valid", {7'd0, bus_if.req_valid}, 8'd0);
    check("midgap_rst_pend", {2'd0, bus_if.pending}, 8'd0);
    tick(1);
    rst_n = 1'b1;
    n_hits = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (bus_if.req_valid || bus_if.req_code != 3'b000) n_hits++;
    end
    check("post_rst_idle", 8'(n_hits), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
